// File: rtl/responder_pkg.sv
// Shared types for the quiz responder: FSM states, BCD digit, display enable masks.
// RESPONDER_FOUL_EN adds the FOUL (false-start) state.
package responder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      LOCKED,
      DONE
`ifdef RESPONDER_FOUL_EN
      , FOUL
`endif
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam logic [7:0] ENC_BASE = 8'b0000_0011;
   localparam logic [7:0] ENC_WIN  = 8'b1000_0000;

   // Returns {tens, ones} decremented by one second; x0 borrows to (x-1)9.
   function automatic logic [7:0] bcd_dec(input bcd_t tens, input bcd_t ones);
      if (ones == 4'd0) return {tens - 4'd1, 4'd9};
      else              return {tens, ones - 4'd1};
   endfunction

endpackage

// File: rtl/responder_tick.sv
// Seconds prescaler: counts 0..TICK_DIV-1, tick_o is high in the wrap cycle.
module responder_tick #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr_i)       cnt_q <= '0;
      else if (cnt_q == LAST) cnt_q <= '0;
      else                    cnt_q <= cnt_q + W'(1);
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/responder_arbiter.sv
// Quiz-responder controller: buzz window, first-press latch, answer countdown, display drive.
// Define RESPONDER_FOUL_EN to flag presses in IDLE as false starts.
module responder_arbiter
   import responder_pkg::*;
#(
   parameter int TICK_DIV    = 100_000_000,
   parameter int BUZZ_SECS   = 10,
   parameter int ANSWER_SECS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       clear,
   input  logic [7:0] btn,
   output logic [3:0] bit0,
   output logic [3:0] bit1,
   output logic [3:0] bit2,
   output logic [3:0] bit3,
   output logic [3:0] bit4,
   output logic [3:0] bit5,
   output logic [3:0] bit6,
   output logic [3:0] bit7,
   output logic [7:0] encontrol,
   output logic [7:0] en_dp,
   output logic [2:0] winner,
   output logic       winner_valid,
   output logic       foul,
   output logic       buzz
);

   localparam bcd_t BUZZ_TENS = bcd_t'(BUZZ_SECS / 10);
   localparam bcd_t BUZZ_ONES = bcd_t'(BUZZ_SECS % 10);
   localparam bcd_t ANS_TENS  = bcd_t'(ANSWER_SECS / 10);
   localparam bcd_t ANS_ONES  = bcd_t'(ANSWER_SECS % 10);

   logic [7:0] btn_q1, btn_q2, edge_w;
   logic       edge_any;
   logic [2:0] edge_idx;
   state_t     state_q;
   bcd_t       tens_q, ones_q, bit7_q;
   logic [2:0] winner_q;
   logic       wv_q, foul_q, buzz_q, en7_q, dp0_q;
   logic       tick_w, last_sec, final_tick, foul_go, pre_clr;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q1 <= '0;
         btn_q2 <= '0;
      end else begin
         btn_q1 <= btn;
         btn_q2 <= btn_q1;
      end
   end

   assign edge_w   = btn_q1 & ~btn_q2;
   assign edge_any = |edge_w;

   always_comb begin
      edge_idx = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (edge_w[i]) edge_idx = 3'(i);
   end

   assign last_sec   = (tens_q == 4'd0) && (ones_q == 4'd1);
   assign final_tick = tick_w && last_sec;
`ifdef RESPONDER_FOUL_EN
   assign foul_go = edge_any;
`else
   assign foul_go = 1'b0;
`endif

   // Prescaler restarts on every state entry so each phase gets whole seconds.
   assign pre_clr = clear
                 || ((state_q == IDLE)   && (start || foul_go))
                 || ((state_q == ARMED)  && (edge_any || final_tick))
                 || ((state_q == LOCKED) && final_tick);

   responder_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (pre_clr),
      .tick_o (tick_w)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         tens_q   <= BUZZ_TENS;
         ones_q   <= BUZZ_ONES;
         winner_q <= 3'd0;
         wv_q     <= 1'b0;
         foul_q   <= 1'b0;
         buzz_q   <= 1'b0;
         bit7_q   <= 4'd0;
         en7_q    <= 1'b0;
         dp0_q    <= 1'b0;
      end else begin
         buzz_q <= 1'b0;
         if (clear) begin
            state_q <= IDLE;
            tens_q  <= BUZZ_TENS;
            ones_q  <= BUZZ_ONES;
            wv_q    <= 1'b0;
            foul_q  <= 1'b0;
            bit7_q  <= 4'd0;
            en7_q   <= 1'b0;
            dp0_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  tens_q <= BUZZ_TENS;
                  ones_q <= BUZZ_ONES;
                  if (start) begin
                     state_q <= ARMED;
                  end
`ifdef RESPONDER_FOUL_EN
                  else if (edge_any) begin
                     state_q  <= FOUL;
                     winner_q <= edge_idx;
                     foul_q   <= 1'b1;
                     buzz_q   <= 1'b1;
                     bit7_q   <= {1'b0, edge_idx} + 4'd1;
                     en7_q    <= 1'b1;
                  end
`endif
               end
               ARMED: begin
                  if (edge_any) begin
                     state_q  <= LOCKED;
                     winner_q <= edge_idx;
                     wv_q     <= 1'b1;
                     buzz_q   <= 1'b1;
                     bit7_q   <= {1'b0, edge_idx} + 4'd1;
                     en7_q    <= 1'b1;
                     tens_q   <= ANS_TENS;
                     ones_q   <= ANS_ONES;
                  end else if (tick_w) begin
                     {tens_q, ones_q} <= bcd_dec(tens_q, ones_q);
                     if (last_sec) begin
                        state_q <= DONE;
                        buzz_q  <= 1'b1;
                        dp0_q   <= 1'b1;
                     end
                  end
               end
               LOCKED: begin
                  if (tick_w) begin
                     {tens_q, ones_q} <= bcd_dec(tens_q, ones_q);
                     if (last_sec) begin
                        state_q <= DONE;
                        buzz_q  <= 1'b1;
                        dp0_q   <= 1'b1;
                     end
                  end
               end
               DONE: ;
`ifdef RESPONDER_FOUL_EN
               FOUL: ;
`endif
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bit0         = ones_q;
   assign bit1         = tens_q;
   assign bit2         = 4'd0;
   assign bit3         = 4'd0;
   assign bit4         = 4'd0;
   assign bit5         = 4'd0;
   assign bit6         = 4'd0;
   assign bit7         = bit7_q;
   assign encontrol    = ENC_BASE | (en7_q ? ENC_WIN : 8'h00);
   assign en_dp        = {foul_q, 6'b0, dp0_q};
   assign winner       = winner_q;
   assign winner_valid = wv_q;
   assign foul         = foul_q;
   assign buzz         = buzz_q;

endmodule

// File: tb/tb_responder_arbiter.sv
// Directed bench for responder_arbiter (TICK_DIV=4, BUZZ_SECS=3, ANSWER_SECS=5).
module tb_responder_arbiter;

   logic       clk = 1'b0;
   logic       rst, start, clear;
   logic [7:0] btn;
   logic [3:0] bit0, bit1, bit2, bit3, bit4, bit5, bit6, bit7;
   logic [7:0] encontrol, en_dp;
   logic [2:0] winner;
   logic       winner_valid, foul, buzz;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   responder_arbiter #(.TICK_DIV(4), .BUZZ_SECS(3), .ANSWER_SECS(5)) dut (
      .clk(clk), .rst(rst), .start(start), .clear(clear), .btn(btn),
      .bit0(bit0), .bit1(bit1), .bit2(bit2), .bit3(bit3),
      .bit4(bit4), .bit5(bit5), .bit6(bit6), .bit7(bit7),
      .encontrol(encontrol), .en_dp(en_dp), .winner(winner),
      .winner_valid(winner_valid), .foul(foul), .buzz(buzz)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; clear = 1'b0; btn = 8'h00;
      step(2);
      rst = 1'b0;
      check("rst_secs",  {bit1, bit0}, 8'h03);
      check("rst_enc",   encontrol, 8'h03);
      check("rst_dp",    en_dp, 8'h00);
      check("rst_wv",    winner_valid, 0);
      check("rst_buzz",  buzz, 0);
      check("rst_bit7",  bit7, 0);
      check("rst_mid",   {bit6, bit5, bit4, bit3, bit2}, 0);
      check("rst_foul",  foul, 0);
      step(3);
      check("idle_hold", {bit1, bit0}, 8'h03);

      // buzz-window timeout
      start = 1'b1; step(1); start = 1'b0;
      check("to_e0",   {bit1, bit0}, 8'h03);
      step(3);  check("to_e3",   {bit1, bit0}, 8'h03);
      step(1);  check("to_e4",   {bit1, bit0}, 8'h02);
      step(4);  check("to_e8",   {bit1, bit0}, 8'h01);
      step(3);  check("to_e11",  {bit1, bit0}, 8'h01);
      check("to_dp11",  en_dp, 8'h00);
      check("to_bz11",  buzz, 0);
      step(1);  check("to_e12",  {bit1, bit0}, 8'h00);
      check("to_dp12",  en_dp, 8'h01);
      check("to_bz12",  buzz, 1);
      step(1);  check("to_bz13", buzz, 0);
      check("to_hold",  {bit1, bit0}, 8'h00);
      clear = 1'b1; step(1); clear = 1'b0;
      check("to_clr_secs", {bit1, bit0}, 8'h03);
      check("to_clr_dp",   en_dp, 8'h00);

      // simultaneous presses during ARMED, then answer countdown
      start = 1'b1; step(1); start = 1'b0;
      step(1); btn = 8'b0010_0100;
      step(1); check("sim_wv_early", winner_valid, 0);
      step(1);
      check("sim_wv",     winner_valid, 1);
      check("sim_winner", winner, 2);
      check("sim_bit7",   bit7, 3);
      check("sim_enc",    encontrol, 8'h83);
      check("sim_secs",   {bit1, bit0}, 8'h05);
      check("sim_buzz",   buzz, 1);
      btn = 8'h01;
      step(2);
      check("sim_late_winner", winner, 2);
      check("sim_late_buzz",   buzz, 0);
      check("sim_late_secs",   {bit1, bit0}, 8'h05);
      btn = 8'h00;
      step(2);  check("ans_l4",  {bit1, bit0}, 8'h04);
      step(15); check("ans_l19", {bit1, bit0}, 8'h01);
      check("ans_dp19", en_dp, 8'h00);
      step(1);
      check("ans_secs",   {bit1, bit0}, 8'h00);
      check("ans_dp",     en_dp, 8'h01);
      check("ans_buzz",   buzz, 1);
      check("ans_winner", winner, 2);
      check("ans_bit7",   bit7, 3);
      step(3);  check("ans_hold", {bit1, bit0}, 8'h00);
      clear = 1'b1; step(1); clear = 1'b0;
      check("ans_clr_enc",  encontrol, 8'h83 & 8'h03);
      check("ans_clr_secs", {bit1, bit0}, 8'h03);
      check("ans_clr_wv",   winner_valid, 0);

      // clear in LOCKED coinciding with a tick; held button after clear
      start = 1'b1; step(1); start = 1'b0;
      btn = 8'h80;
      step(2);
      check("mc_wv",     winner_valid, 1);
      check("mc_winner", winner, 7);
      check("mc_bit7",   bit7, 8);
      step(3); clear = 1'b1; step(1); clear = 1'b0;
      check("mc_secs", {bit1, bit0}, 8'h03);
      check("mc_wv0",  winner_valid, 0);
      check("mc_enc",  encontrol, 8'h03);
      step(3);
      check("mc_held_foul", foul, 0);
      check("mc_held_bit7", bit7, 0);
      start = 1'b1; step(1); start = 1'b0;
      step(3); check("mc_held_wv", winner_valid, 0);
      btn = 8'h00; step(1);
      check("mc_tick", {bit1, bit0}, 8'h02);
      btn = 8'h80; step(2);
      check("mc_repress_wv",   winner_valid, 1);
      check("mc_repress_win",  winner, 7);
      check("mc_repress_secs", {bit1, bit0}, 8'h05);
      btn = 8'h00;
      clear = 1'b1; step(1); clear = 1'b0;
      step(2);

      // start and an edge in the same IDLE cycle: edge discarded
      btn = 8'h02; step(1);
      start = 1'b1; step(1); start = 1'b0;
      check("se_foul", foul, 0);
      step(2);
      check("se_wv",   winner_valid, 0);
      check("se_secs", {bit1, bit0}, 8'h03);
      step(2);
      check("se_tick", {bit1, bit0}, 8'h02);
      btn = 8'h00;
      clear = 1'b1; step(1); clear = 1'b0;
      step(2);

      // press in IDLE without start
      btn = 8'h40; step(2);
`ifdef RESPONDER_FOUL_EN
      check("fs_foul",   foul, 1);
      check("fs_bit7",   bit7, 7);
      check("fs_dp",     en_dp, 8'h80);
      check("fs_buzz",   buzz, 1);
      check("fs_winner", winner, 6);
      check("fs_wv",     winner_valid, 0);
      check("fs_enc",    encontrol, 8'h83);
      btn = 8'h00;
      start = 1'b1; step(1); start = 1'b0;
      step(6);
      check("fs_start_ign", {bit1, bit0}, 8'h03);
      check("fs_hold_foul", foul, 1);
      check("fs_buzz_once", buzz, 0);
      clear = 1'b1; step(1); clear = 1'b0;
      check("fs_clr_foul", foul, 0);
      check("fs_clr_dp",   en_dp, 8'h00);
`else
      check("nf_foul", foul, 0);
      check("nf_buzz", buzz, 0);
      check("nf_dp",   en_dp, 8'h00);
      check("nf_enc",  encontrol, 8'h03);
      btn = 8'h00;
      step(6);
      check("nf_secs", {bit1, bit0}, 8'h03);
      check("nf_wv",   winner_valid, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
